// File: rtl/im_param_if.sv
// Fetch request/response bus between an instruction consumer and im_param.
// The slave modport is the memory side; master is the fetching side.
interface im_param_if;
  logic        req;
  logic [31:0] addr;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] data;
  logic        fault;

  modport slave (
    input  req, addr, rsp_ready,
    output req_ready, rsp_valid, data, fault
  );

  modport master (
    output req, addr, rsp_ready,
    input  req_ready, rsp_valid, data, fault
  );
endinterface

// File: rtl/im_param.sv
// Instruction memory with a programmable read latency and a program-load port.
// One fetch in flight; the response is held until the consumer takes it.
module im_param #(
  parameter int ADDR_BITS   = 7,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  im_param_if.slave   bus,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_nxt;
  logic [ADDR_BITS-1:0] r_idx;
  logic [ADDR_BITS-1:0] w_idx_nxt;
  logic                 r_oor;
  logic                 w_oor_nxt;
  logic                 w_enter_resp;
  logic                 w_ld_oor;
  logic                 r_req_ready;
  logic                 r_rsp_valid;
  logic [31:0]          r_data;
  logic                 r_fault;
  logic [31:0]          r_mem [DEPTH];
  logic                 w_unused;

  // Any set bit above the word index means the byte address lies beyond memory.
  function automatic logic out_of_range(input logic [31:0] a);
    return |a[31:ADDR_BITS+2];
  endfunction

  assign w_ld_oor = out_of_range(ld_addr);
  assign w_unused = ^{bus.addr[1:0], ld_addr[1:0]};

  // Next-state, wait counter and captured fetch index/range.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_oor_nxt   = r_oor;
    case (r_state)
      IDLE: begin
        if (bus.req) begin
          w_idx_nxt   = bus.addr[ADDR_BITS+1:2];
          w_oor_nxt   = out_of_range(bus.addr);
          w_cnt_nxt   = WS;
          w_state_nxt = (WS == 4'd0) ? RESP : WAIT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_enter_resp = (w_state_nxt == RESP) && (r_state != RESP);
  end

  // FSM registers and registered outputs; memory is read on the edge entering RESP,
  // so a load on that same edge is not seen by this response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_idx       <= '0;
      r_oor       <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_data      <= 32'h0000_0000;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_oor       <= w_oor_nxt;
      r_req_ready <= (w_state_nxt == IDLE);
      r_rsp_valid <= (w_state_nxt == RESP);
      if (w_enter_resp) begin
        r_data  <= w_oor_nxt ? 32'h0000_0000 : r_mem[w_idx_nxt];
        r_fault <= w_oor_nxt;
      end
    end
  end

  // Program-load port; deliberately outside reset so memory survives it.
  always_ff @(posedge clk) begin
    if (ld_en && !w_ld_oor) begin
      r_mem[ld_addr[ADDR_BITS+1:2]] <= ld_data;
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.data      = r_data;
  assign bus.fault     = r_fault;
endmodule

// File: tb/tb_im_param.sv
// Scoreboard bench for im_param: instance 0 has no wait states, instance 1 has three.
`timescale 1ns/1ps
module tb_im_param;
  localparam int AB  = 7;
  localparam int WS0 = 0;
  localparam int WS1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a     [2];
  logic        ld_en_a     [2];
  logic [31:0] ld_addr_a   [2];
  logic [31:0] ld_data_a   [2];
  logic        req_a       [2];
  logic [31:0] addr_a      [2];
  logic        rsp_ready_a [2];
  logic        req_ready_a [2];
  logic        rsp_valid_a [2];
  logic [31:0] data_a      [2];
  logic        fault_a     [2];

  im_param_if if0 ();
  im_param_if if1 ();

  assign if0.req        = req_a[0];
  assign if0.addr       = addr_a[0];
  assign if0.rsp_ready  = rsp_ready_a[0];
  assign req_ready_a[0] = if0.req_ready;
  assign rsp_valid_a[0] = if0.rsp_valid;
  assign data_a[0]      = if0.data;
  assign fault_a[0]     = if0.fault;
  assign if1.req        = req_a[1];
  assign if1.addr       = addr_a[1];
  assign if1.rsp_ready  = rsp_ready_a[1];
  assign req_ready_a[1] = if1.req_ready;
  assign rsp_valid_a[1] = if1.rsp_valid;
  assign data_a[1]      = if1.data;
  assign fault_a[1]     = if1.fault;

  im_param #(.ADDR_BITS(AB), .WAIT_STATES(WS0)) u_ws0 (
    .clk(clk), .reset(reset_a[0]), .bus(if0.slave),
    .ld_en(ld_en_a[0]), .ld_addr(ld_addr_a[0]), .ld_data(ld_data_a[0])
  );
  im_param #(.ADDR_BITS(AB), .WAIT_STATES(WS1)) u_ws3 (
    .clk(clk), .reset(reset_a[1]), .bus(if1.slave),
    .ld_en(ld_en_a[1]), .ld_addr(ld_addr_a[1]), .ld_data(ld_data_a[1])
  );

  logic [31:0] mdl [2][128];
  logic [32:0] sb [$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic load(input int s, input logic [31:0] a, input logic [31:0] d);
    ld_en_a[s] = 1'b1; ld_addr_a[s] = a; ld_data_a[s] = d;
    if (a[31:AB+2] == 23'd0) mdl[s][a[AB+1:2]] = d;
    @(negedge clk);
    ld_en_a[s] = 1'b0;
  endtask

  // Expected {fault,data} is pushed as the request is driven into an idle DUT.
  task automatic issue(input int s, input logic [31:0] a);
    req_a[s] = 1'b1; addr_a[s] = a;
    if (a[31:AB+2] != 23'd0) sb.push_back({1'b1, 32'h0000_0000});
    else                     sb.push_back({1'b0, mdl[s][a[AB+1:2]]});
    @(negedge clk);
    req_a[s] = 1'b0;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      n_cmp++; if (req_ready_a[s] !== 1'b1) begin n_err++; $display("FAIL reset_req_ready[%0d]: got %b want 1", s, req_ready_a[s]); end
      n_cmp++; if (rsp_valid_a[s] !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid[%0d]: got %b want 0", s, rsp_valid_a[s]); end
      n_cmp++; if (data_a[s] !== 32'h0) begin n_err++; $display("FAIL reset_data[%0d]: got %h want 0", s, data_a[s]); end
      n_cmp++; if (fault_a[s] !== 1'b0) begin n_err++; $display("FAIL reset_fault[%0d]: got %b want 0", s, fault_a[s]); end
    end
  endtask

  task automatic test_ws0_basic();
    logic [32:0] exp;
    int lat;
    load(0, 32'h14, 32'hDEAD_BEEF);
    issue(0, 32'h14);
    lat = 1;
    while (rsp_valid_a[0] !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    n_cmp++; if (lat !== WS0 + 1) begin n_err++; $display("FAIL ws0_latency: got %0d want %0d", lat, WS0 + 1); end
    exp = sb.pop_front();
    n_cmp++; if ({fault_a[0], data_a[0]} !== exp) begin n_err++; $display("FAIL ws0_data: got %b/%h want %b/%h", fault_a[0], data_a[0], exp[32], exp[31:0]); end
    @(negedge clk);
    n_cmp++; if (req_ready_a[0] !== 1'b1 || rsp_valid_a[0] !== 1'b0) begin n_err++; $display("FAIL ws0_back_idle: got rdy=%b vld=%b want 1/0", req_ready_a[0], rsp_valid_a[0]); end
  endtask

  task automatic test_ws3_wait();
    logic [32:0] exp;
    int lat;
    load(1, 32'h08, 32'h1234_5678);
    issue(1, 32'h0B);
    lat = 1;
    while (rsp_valid_a[1] !== 1'b1 && lat < 40) begin
      n_cmp++; if (req_ready_a[1] !== 1'b0) begin n_err++; $display("FAIL ws3_busy_ready: got %b want 0 at cycle %0d", req_ready_a[1], lat); end
      @(negedge clk); lat++;
    end
    n_cmp++; if (lat !== WS1 + 1) begin n_err++; $display("FAIL ws3_latency: got %0d want %0d", lat, WS1 + 1); end
    exp = sb.pop_front();
    n_cmp++; if ({fault_a[1], data_a[1]} !== exp) begin n_err++; $display("FAIL ws3_data: got %b/%h want %b/%h", fault_a[1], data_a[1], exp[32], exp[31:0]); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [32:0] exp;
    int lat;
    load(1, 32'h40, 32'hCAFE_F00D);
    rsp_ready_a[1] = 1'b0;
    issue(1, 32'h40);
    lat = 1;
    while (rsp_valid_a[1] !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    n_cmp++; if (lat !== WS1 + 1) begin n_err++; $display("FAIL bp_latency: got %0d want %0d", lat, WS1 + 1); end
    exp = sb.pop_front();
    // A competing request held during RESP must be ignored.
    req_a[1] = 1'b1; addr_a[1] = 32'h44;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (rsp_valid_a[1] !== 1'b1 || {fault_a[1], data_a[1]} !== exp) begin n_err++; $display("FAIL bp_hold[%0d]: got vld=%b %h want 1 %h", i, rsp_valid_a[1], data_a[1], exp[31:0]); end
      @(negedge clk);
    end
    req_a[1] = 1'b0; rsp_ready_a[1] = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready_a[1] !== 1'b1 || rsp_valid_a[1] !== 1'b0) begin n_err++; $display("FAIL bp_release: got rdy=%b vld=%b want 1/0", req_ready_a[1], rsp_valid_a[1]); end
  endtask

  task automatic test_out_of_range();
    logic [32:0] exp;
    load(0, 32'h0, 32'h1111_1111);
    issue(0, 32'h200);
    n_cmp++; if (rsp_valid_a[0] !== 1'b1) begin n_err++; $display("FAIL oor_valid: got %b want 1", rsp_valid_a[0]); end
    exp = sb.pop_front();
    n_cmp++; if ({fault_a[0], data_a[0]} !== exp) begin n_err++; $display("FAIL oor_fetch: got %b/%h want %b/%h", fault_a[0], data_a[0], exp[32], exp[31:0]); end
    @(negedge clk);
    load(0, 32'h200, 32'hBADB_AD00);
    load(0, 32'h8000_0000, 32'hBADB_AD01);
    issue(0, 32'h0);
    exp = sb.pop_front();
    n_cmp++; if ({fault_a[0], data_a[0]} !== exp) begin n_err++; $display("FAIL oor_load_ignored: got %b/%h want %b/%h", fault_a[0], data_a[0], exp[32], exp[31:0]); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [32:0] exp;
    int lat;
    load(1, 32'h20, 32'hA5A5_0001);
    issue(1, 32'h20);
    @(negedge clk);
    // Reset lands in WAIT; a load issued during reset must still take effect.
    reset_a[1] = 1'b1;
    ld_en_a[1] = 1'b1; ld_addr_a[1] = 32'h20; ld_data_a[1] = 32'hA5A5_0002;
    mdl[1][8] = 32'hA5A5_0002;
    @(negedge clk);
    reset_a[1] = 1'b0; ld_en_a[1] = 1'b0;
    sb.delete();
    n_cmp++; if (req_ready_a[1] !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %b want 1", req_ready_a[1]); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (rsp_valid_a[1] !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_rsp[%0d]: got %b want 0", i, rsp_valid_a[1]); end
      @(negedge clk);
    end
    issue(1, 32'h20);
    lat = 1;
    while (rsp_valid_a[1] !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    n_cmp++; if (lat !== WS1 + 1) begin n_err++; $display("FAIL rst_mid_latency: got %0d want %0d", lat, WS1 + 1); end
    exp = sb.pop_front();
    n_cmp++; if ({fault_a[1], data_a[1]} !== exp) begin n_err++; $display("FAIL rst_mid_data: got %b/%h want %b/%h", fault_a[1], data_a[1], exp[32], exp[31:0]); end
    @(negedge clk);
  endtask

  task automatic test_collision();
    logic [32:0] exp;
    int lat;
    load(1, 32'h10, 32'hAAAA_0004);
    issue(1, 32'h10);
    @(negedge clk);
    @(negedge clk);
    // This load shares the edge that enters RESP: the response keeps the old word.
    ld_en_a[1] = 1'b1; ld_addr_a[1] = 32'h10; ld_data_a[1] = 32'hBBBB_0004;
    mdl[1][4] = 32'hBBBB_0004;
    @(negedge clk);
    ld_en_a[1] = 1'b0;
    n_cmp++; if (rsp_valid_a[1] !== 1'b1) begin n_err++; $display("FAIL coll_valid: got %b want 1", rsp_valid_a[1]); end
    exp = sb.pop_front();
    n_cmp++; if ({fault_a[1], data_a[1]} !== exp) begin n_err++; $display("FAIL coll_old: got %b/%h want %b/%h", fault_a[1], data_a[1], exp[32], exp[31:0]); end
    @(negedge clk);
    issue(1, 32'h10);
    lat = 1;
    while (rsp_valid_a[1] !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    exp = sb.pop_front();
    n_cmp++; if ({fault_a[1], data_a[1]} !== exp) begin n_err++; $display("FAIL coll_new: got %b/%h want %b/%h", fault_a[1], data_a[1], exp[32], exp[31:0]); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    localparam int N = 8;
    logic [32:0] exp;
    logic [31:0] a;
    int sent, got, cyc;
    for (int i = 0; i < N; i++) load(0, 32'(64 + 4 * i), $urandom);
    sent = 0; got = 0; cyc = 0;
    while (got < N && cyc < 200) begin
      if (rsp_valid_a[0] === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL b2b_unexpected: got %h want no response", data_a[0]); end
        else begin
          exp = sb.pop_front();
          if ({fault_a[0], data_a[0]} !== exp) begin n_err++; $display("FAIL b2b_data[%0d]: got %b/%h want %b/%h", got, fault_a[0], data_a[0], exp[32], exp[31:0]); end
        end
        got++;
      end
      if (sent < N && req_ready_a[0] === 1'b1) begin
        a = (sent == 3) ? 32'h0001_0040 : 32'(64 + 4 * $urandom_range(N - 1, 0) + $urandom_range(3, 0));
        req_a[0] = 1'b1; addr_a[0] = a;
        if (a[31:AB+2] != 23'd0) sb.push_back({1'b1, 32'h0000_0000});
        else                     sb.push_back({1'b0, mdl[0][a[AB+1:2]]});
        sent++;
      end else if (sent < N) begin
        req_a[0] = 1'b1; addr_a[0] = $urandom;
      end else begin
        req_a[0] = 1'b0;
      end
      @(negedge clk); cyc++;
    end
    req_a[0] = 1'b0;
    n_cmp++; if (got !== N) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", got, N); end
    n_cmp++; if (cyc !== N * (WS0 + 2)) begin n_err++; $display("FAIL b2b_period: got %0d cycles want %0d", cyc, N * (WS0 + 2)); end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      reset_a[s] = 1'b1; ld_en_a[s] = 1'b0; ld_addr_a[s] = 32'h0; ld_data_a[s] = 32'h0;
      req_a[s] = 1'b0; addr_a[s] = 32'h0; rsp_ready_a[s] = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
    reset_a[0] = 1'b0; reset_a[1] = 1'b0;
    test_reset();
    test_ws0_basic();
    test_ws3_wait();
    test_backpressure();
    test_out_of_range();
    test_reset_mid();
    test_collision();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
